// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: produces a divided slow_clk and a one-cycle tick from clk.
// Config (divisor, run/stop) is taken over valid/ready and only ever applied on a tick edge.
module clk_en_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic             cfg_run,
   output logic             tick,
   output logic             slow_clk,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] div_q, div_n;
   logic             slow_n;
   logic             pend_valid, pv_n;
   logic [WIDTH-1:0] pend_div, pd_n;
   logic             pend_run, pr_n;

   logic             accept;
   logic [WIDTH-1:0] app_div;
   logic             app_run;

   assign tick = (state != IDLE) && (cnt == div_q);
   assign busy = (state != IDLE);

   // Ready is a function of state and pend_valid only, never of cfg_valid.
   always_comb begin
      cfg_ready = 1'b0;
      case (state)
         IDLE:    cfg_ready = 1'b1;
         RUN:     cfg_ready = !pend_valid;
         default: cfg_ready = 1'b0;
      endcase
   end

   assign accept = cfg_valid && cfg_ready;

   // A request accepted on the tick cycle itself applies at that same edge.
   assign app_div = pend_valid ? pend_div : cfg_div;
   assign app_run = pend_valid ? pend_run : cfg_run;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      div_n   = div_q;
      slow_n  = slow_clk;
      pv_n    = pend_valid;
      pd_n    = pend_div;
      pr_n    = pend_run;

      if (tick)
         slow_n = ~slow_clk;

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (accept) begin
               div_n = cfg_div;
               if (cfg_run)
                  state_n = RUN;
            end
         end

         RUN: begin
            if (tick) begin
               cnt_n = '0;
               if (pend_valid || accept) begin
                  div_n = app_div;
                  if (app_run) begin
                     pv_n = 1'b0;
                  end else if (slow_clk) begin
                     // This edge drives slow_clk low, so the stop completes now.
                     state_n = IDLE;
                     pv_n    = 1'b0;
                  end else begin
                     // slow_clk rises here; one more period is needed to bring it low.
                     state_n = DRAIN;
                     pv_n    = 1'b1;
                     pd_n    = app_div;
                     pr_n    = 1'b0;
                  end
               end
            end else begin
               cnt_n = WIDTH'(cnt + 1'b1);
               if (accept) begin
                  pv_n = 1'b1;
                  pd_n = cfg_div;
                  pr_n = cfg_run;
               end
            end
         end

         DRAIN: begin
            if (tick) begin
               cnt_n   = '0;
               state_n = IDLE;
               pv_n    = 1'b0;
            end else begin
               cnt_n = WIDTH'(cnt + 1'b1);
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            pv_n    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         div_q      <= '0;
         slow_clk   <= 1'b0;
         pend_valid <= 1'b0;
         pend_div   <= '0;
         pend_run   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         div_q      <= div_n;
         slow_clk   <= slow_n;
         pend_valid <= pv_n;
         pend_div   <= pd_n;
         pend_run   <= pr_n;
      end
   end

endmodule
